// File: rtl/voice_cmd_pkg.sv
// Shared types and constants for the voice-module command frame controller.
package voice_cmd_pkg;

    localparam int unsigned BYTE_W = 8;

    // Frame parser states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_PARAM = 3'd2,
        ST_CKSUM = 3'd3,
        ST_TAIL  = 3'd4
    } state_e;

    // Default frame delimiters
    localparam logic [BYTE_W-1:0] HDR_DEFAULT  = 8'hAA;
    localparam logic [BYTE_W-1:0] TAIL_DEFAULT = 8'h55;

    // Command codes understood by the application side
    localparam logic [BYTE_W-1:0] CMD_NOP      = 8'h00;
    localparam logic [BYTE_W-1:0] CMD_LED_ON   = 8'h01;
    localparam logic [BYTE_W-1:0] CMD_LED_OFF  = 8'h02;
    localparam logic [BYTE_W-1:0] CMD_VOL_UP   = 8'h10;
    localparam logic [BYTE_W-1:0] CMD_VOL_DOWN = 8'h11;
    localparam logic [BYTE_W-1:0] CMD_PLAY     = 8'h20;
    localparam logic [BYTE_W-1:0] CMD_STOP     = 8'h21;

    // Counter width able to hold 0 .. cyc-1, never narrower than one bit
    function automatic int unsigned timeout_width(input int unsigned cyc);
        return (cyc <= 32'd2) ? 32'd1 : 32'($clog2(cyc));
    endfunction

endpackage

// File: rtl/voice_byte_timer.sv
// Inter-byte timer: cleared on demand, counts while run is high,
// flags expiry when the count reaches TIMEOUT_CYC-1.
module voice_byte_timer #(
    parameter int unsigned TIMEOUT_CYC = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic expired_c
);
    import voice_cmd_pkg::*;

    localparam int unsigned CW = timeout_width(TIMEOUT_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 32'd1);

    logic [CW-1:0] cnt_q;

    // Count up while running; held at zero when idle or cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || !run) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Expiry indication for the current cycle
    assign expired_c = run && (cnt_q == CNT_LAST);

endmodule

// File: rtl/voice_cmd_ctrl.sv
// Frame-level controller behind the voice-module UART receiver.
// Parses HDR/CMD/PARAM/[CKSUM]/TAIL frames, enforces an inter-byte timeout
// and hands accepted commands over through a single-entry valid/ready register.
// Build option: VOICE_CMD_CKSUM_EN adds the XOR checksum byte and its check.
module voice_cmd_ctrl
    import voice_cmd_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYC = 500000,
    parameter logic [BYTE_W-1:0] HDR_BYTE    = HDR_DEFAULT,
    parameter logic [BYTE_W-1:0] TAIL_BYTE   = TAIL_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] rx_byte,
    input  logic              rx_byte_vld,
    input  logic              enable,
    input  logic              cmd_ready,
    output logic              cmd_valid,
    output logic [BYTE_W-1:0] cmd_code,
    output logic [BYTE_W-1:0] cmd_param,
    output logic              frame_err,
    output logic              ovf,
    output logic [7:0]        err_cnt
);

    state_e            state_q;
    state_e            state_nxt;
    logic [BYTE_W-1:0] cmd_byte_q;
    logic [BYTE_W-1:0] param_byte_q;
    logic              ld_cmd_c;
    logic              ld_param_c;
    logic              done_c;
    logic              err_c;
    logic              load_c;
    logic              expired_c;
    logic              timer_clr_c;
    logic              timer_run_c;

`ifdef VOICE_CMD_CKSUM_EN
    logic cksum_ok_c;
    assign cksum_ok_c = (rx_byte == (cmd_byte_q ^ param_byte_q));
`endif

    // Timer restarts on every byte and is held while disabled or idle
    assign timer_clr_c = rx_byte_vld || !enable;
    assign timer_run_c = (state_q != ST_IDLE);

    voice_byte_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (timer_clr_c),
        .run       (timer_run_c),
        .expired_c (expired_c)
    );

    // Parser state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state decode; a byte takes priority over a coincident timeout
    always_comb begin
        state_nxt = state_q;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else if (rx_byte_vld) begin
            unique case (state_q)
                ST_IDLE:  if (rx_byte == HDR_BYTE) state_nxt = ST_CMD;
                ST_CMD:   state_nxt = ST_PARAM;
`ifdef VOICE_CMD_CKSUM_EN
                ST_PARAM: state_nxt = ST_CKSUM;
                ST_CKSUM: state_nxt = cksum_ok_c ? ST_TAIL : ST_IDLE;
`else
                ST_PARAM: state_nxt = ST_TAIL;
`endif
                ST_TAIL:  state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end else if (expired_c) begin
            state_nxt = ST_IDLE;
        end
    end

    // Per-cycle strobes: byte latches, frame completion and frame errors
    always_comb begin
        ld_cmd_c   = 1'b0;
        ld_param_c = 1'b0;
        done_c     = 1'b0;
        err_c      = 1'b0;
        if (enable && rx_byte_vld) begin
            unique case (state_q)
                ST_CMD:   ld_cmd_c   = 1'b1;
                ST_PARAM: ld_param_c = 1'b1;
`ifdef VOICE_CMD_CKSUM_EN
                ST_CKSUM: err_c      = !cksum_ok_c;
`endif
                ST_TAIL: begin
                    done_c = (rx_byte == TAIL_BYTE);
                    err_c  = (rx_byte != TAIL_BYTE);
                end
                default: ;
            endcase
        end else if (enable && expired_c) begin
            err_c = 1'b1;
        end
    end

    // Frame payload capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_byte_q   <= '0;
            param_byte_q <= '0;
        end else begin
            if (ld_cmd_c)   cmd_byte_q   <= rx_byte;
            if (ld_param_c) param_byte_q <= rx_byte;
        end
    end

    // Holding register accepts a frame when empty or being drained this cycle
    assign load_c = done_c && (!cmd_valid || cmd_ready);

    // Command holding register and overflow pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid <= 1'b0;
            cmd_code  <= '0;
            cmd_param <= '0;
            ovf       <= 1'b0;
        end else begin
            ovf <= done_c && !load_c;
            if (load_c) begin
                cmd_valid <= 1'b1;
                cmd_code  <= cmd_byte_q;
                cmd_param <= param_byte_q;
            end else if (cmd_ready) begin
                cmd_valid <= 1'b0;
            end
        end
    end

    // Frame error pulse and saturating error counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            frame_err <= err_c;
            if (err_c && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_voice_cmd_ctrl.sv
// Directed bench for voice_cmd_ctrl: frame vector table plus hand-written
// sequences for timeout, overflow, same-cycle drain, enable and reset.
module tb_voice_cmd_ctrl;

    localparam int unsigned TO = 16;
`ifdef VOICE_CMD_CKSUM_EN
    localparam bit CKSUM_EN = 1'b1;
`else
    localparam bit CKSUM_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_byte;
    logic       rx_byte_vld;
    logic       enable;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic [7:0] cmd_param;
    logic       frame_err;
    logic       ovf;
    logic [7:0] err_cnt;

    voice_cmd_ctrl #(
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_byte     (rx_byte),
        .rx_byte_vld (rx_byte_vld),
        .enable      (enable),
        .cmd_ready   (cmd_ready),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .cmd_param   (cmd_param),
        .frame_err   (frame_err),
        .ovf         (ovf),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge
    int err_seen = 0;
    int ovf_seen = 0;
    always @(negedge clk) begin
        if (frame_err) err_seen = err_seen + 1;
        if (ovf)       ovf_seen = ovf_seen + 1;
    end

    int n_chk  = 0;
    int n_fail = 0;
    int exp_errcnt = 0;

    typedef struct {
        logic [39:0] frm;
        logic        exp_valid;
        logic [7:0]  exp_code;
        logic [7:0]  exp_param;
        int          exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [39:0] fr(input logic [7:0] h, input logic [7:0] c,
                                       input logic [7:0] p, input logic [7:0] k,
                                       input logic [7:0] t);
        return {h, c, p, k, t};
    endfunction

    // One strobed byte; returns at the negedge after the byte's active edge
    task automatic send_byte(input logic [7:0] b, input logic rdy);
        @(negedge clk);
        rx_byte     = b;
        rx_byte_vld = 1'b1;
        cmd_ready   = rdy;
        @(negedge clk);
        rx_byte_vld = 1'b0;
        cmd_ready   = 1'b0;
    endtask

    // Frame bytes MSB first; the checksum byte is skipped in the 4-byte build
    task automatic send_frame(input logic [39:0] f, input logic last_rdy);
        for (int i = 0; i < 5; i++) begin
            if (!(i == 3 && !CKSUM_EN)) begin
                send_byte(f[39-8*i -: 8], (i == 4) ? last_rdy : 1'b0);
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        @(negedge clk);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        check("drain_valid", 32'(cmd_valid), 32'd0);
    endtask

    task automatic bump_err(input int n);
        exp_errcnt = exp_errcnt + n;
        if (exp_errcnt > 255) exp_errcnt = 255;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(cmd_valid), 32'd0);
        check({tag, "_code"},  32'(cmd_code),  32'd0);
        check({tag, "_param"}, 32'(cmd_param), 32'd0);
        check({tag, "_ferr"},  32'(frame_err), 32'd0);
        check({tag, "_ovf"},   32'(ovf),       32'd0);
        check({tag, "_errcnt"},32'(err_cnt),   32'd0);
    endtask

    initial begin
        int eb;
        int ob;

        rst_n       = 1'b0;
        rx_byte     = '0;
        rx_byte_vld = 1'b0;
        enable      = 1'b1;
        cmd_ready   = 1'b0;

        // Vector table: frame, expected hold contents, expected error pulses
        vecs.push_back('{fr(8'hAA, 8'h12, 8'h34, 8'h26, 8'h55), 1'b1, 8'h12, 8'h34, 0});
        vecs.push_back('{fr(8'hAA, 8'h01, 8'h02, 8'h03, 8'h55), 1'b1, 8'h01, 8'h02, 0});
        vecs.push_back('{fr(8'hAA, 8'h05, 8'h06, 8'h03, 8'h55), 1'b1, 8'h05, 8'h06, 0});
        vecs.push_back('{fr(8'hAA, 8'hAA, 8'hAA, 8'h00, 8'h55), 1'b1, 8'hAA, 8'hAA, 0});
        vecs.push_back('{fr(8'hAA, 8'h12, 8'h34, 8'h26, 8'h56), 1'b0, 8'h00, 8'h00, 1});
        vecs.push_back('{fr(8'hAA, 8'h55, 8'hAA, 8'hFF, 8'h55), 1'b1, 8'h55, 8'hAA, 0});
        if (CKSUM_EN) begin
            vecs.push_back('{fr(8'hAA, 8'h12, 8'h34, 8'h27, 8'h55), 1'b0, 8'h00, 8'h00, 1});
        end

        // Reset values
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Table-driven frames, each drained afterwards
        foreach (vecs[i]) begin
            eb = err_seen;
            ob = ovf_seen;
            send_frame(vecs[i].frm, 1'b0);
            check("vec_valid", 32'(cmd_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check("vec_code",  32'(cmd_code),  32'(vecs[i].exp_code));
                check("vec_param", 32'(cmd_param), 32'(vecs[i].exp_param));
            end
            settle();
            check("vec_err_pulses", err_seen - eb, vecs[i].exp_err);
            check("vec_ovf_pulses", ovf_seen - ob, 0);
            bump_err(vecs[i].exp_err);
            check("vec_errcnt", 32'(err_cnt), exp_errcnt);
            drain();
        end

        // Checksum error pulse lands right after the bad checksum byte
        if (CKSUM_EN) begin
            send_byte(8'hAA, 1'b0);
            send_byte(8'h12, 1'b0);
            send_byte(8'h34, 1'b0);
            send_byte(8'h27, 1'b0);
            check("cksum_err_pulse", 32'(frame_err), 32'd1);
            bump_err(1);
            check("cksum_errcnt", 32'(err_cnt), exp_errcnt);
            send_byte(8'h55, 1'b0);
            check("cksum_no_valid", 32'(cmd_valid), 32'd0);
            send_frame(fr(8'hAA, 8'h01, 8'h02, 8'h03, 8'h55), 1'b0);
            check("cksum_next_valid", 32'(cmd_valid), 32'd1);
            check("cksum_next_code", 32'(cmd_code), 32'h01);
            drain();
        end

        // Inter-byte timeout mid-frame
        eb = err_seen;
        send_byte(8'hAA, 1'b0);
        send_byte(8'h12, 1'b0);
        for (int k = 0; k < int'(TO) + 4; k++) @(negedge clk);
        #1;
        check("timeout_pulses", err_seen - eb, 1);
        bump_err(1);
        check("timeout_errcnt", 32'(err_cnt), exp_errcnt);
        send_frame(fr(8'hAA, 8'h05, 8'h06, 8'h03, 8'h55), 1'b0);
        check("timeout_next_valid", 32'(cmd_valid), 32'd1);
        check("timeout_next_code", 32'(cmd_code), 32'h05);
        check("timeout_next_param", 32'(cmd_param), 32'h06);
        drain();

        // Overflow: second frame dropped while first is held
        ob = ovf_seen;
        send_frame(fr(8'hAA, 8'h11, 8'h22, 8'h33, 8'h55), 1'b0);
        send_frame(fr(8'hAA, 8'h33, 8'h44, 8'h77, 8'h55), 1'b0);
        check("ovf_pulse", 32'(ovf), 32'd1);
        check("ovf_valid", 32'(cmd_valid), 32'd1);
        check("ovf_code_kept", 32'(cmd_code), 32'h11);
        check("ovf_param_kept", 32'(cmd_param), 32'h22);
        settle();
        check("ovf_pulses", ovf_seen - ob, 1);

        // Frame completes in the same cycle the held command is taken
        ob = ovf_seen;
        send_frame(fr(8'hAA, 8'h77, 8'h88, 8'hFF, 8'h55), 1'b1);
        check("swap_valid", 32'(cmd_valid), 32'd1);
        check("swap_code", 32'(cmd_code), 32'h77);
        check("swap_param", 32'(cmd_param), 32'h88);
        check("swap_no_ovf", 32'(ovf), 32'd0);
        settle();
        check("swap_ovf_pulses", ovf_seen - ob, 0);
        drain();

        // Noise in IDLE is ignored silently
        eb = err_seen;
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h55, 1'b0);
        settle();
        check("noise_err", err_seen - eb, 0);
        check("noise_valid", 32'(cmd_valid), 32'd0);

        // Disable mid-frame discards the partial frame without error
        eb = err_seen;
        send_byte(8'hAA, 1'b0);
        send_byte(8'h12, 1'b0);
        @(negedge clk);
        enable = 1'b0;
        send_byte(8'hAA, 1'b0);
        @(negedge clk);
        enable = 1'b1;
        send_frame(fr(8'hAA, 8'h21, 8'h43, 8'h62, 8'h55), 1'b0);
        check("enable_valid", 32'(cmd_valid), 32'd1);
        check("enable_code", 32'(cmd_code), 32'h21);
        check("enable_param", 32'(cmd_param), 32'h43);
        settle();
        check("enable_err", err_seen - eb, 0);
        drain();

        // Error counter saturates at 255
        for (int n = 0; n < 260; n++) begin
            send_frame(fr(8'hAA, 8'h12, 8'h34, 8'h26, 8'h56), 1'b0);
            bump_err(1);
        end
        settle();
        check("errcnt_saturate", 32'(err_cnt), exp_errcnt);

        // Asynchronous reset mid-frame with a command held
        send_frame(fr(8'hAA, 8'h01, 8'h02, 8'h03, 8'h55), 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'h12, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_errcnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        eb = err_seen;
        ob = ovf_seen;
        for (int k = 0; k < int'(TO) + 4; k++) @(negedge clk);
        #1;
        check("release_err", err_seen - eb, 0);
        check("release_ovf", ovf_seen - ob, 0);
        send_frame(fr(8'hAA, 8'h10, 8'h20, 8'h30, 8'h55), 1'b0);
        check("after_reset_valid", 32'(cmd_valid), 32'd1);
        check("after_reset_code", 32'(cmd_code), 32'h10);
        check("after_reset_param", 32'(cmd_param), 32'h20);
        check("after_reset_errcnt", 32'(err_cnt), exp_errcnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
